// File: rtl/palindrome_check_sched_pkg.sv
// Shared types and helpers for the palindrome checker scheduler.
// Holds the default word width, the response record and the round-robin pick function.
package palindrome_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_IDW   = 2;
    localparam int MAX_NREQ  = 32;
    localparam int IDX_W     = 5;

    typedef struct packed {
        logic [DEF_IDW-1:0]   id;
        logic                 is_pal;
        logic [DEF_WIDTH-1:0] word;
    } rsp_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] index;
    } pick_t;

    // First set bit of valid at or above ptr, wrapping at nreq.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                      input int ptr, input int nreq);
        pick_t p;
        int    idx;
        p = '0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            idx = ptr + k;
            if (idx >= nreq) idx = idx - nreq;
            if (k < nreq && !p.found && valid[idx[IDX_W-1:0]]) begin
                p.found = 1'b1;
                p.index = idx[IDX_W-1:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/palindrome_check_sched_if.sv
// Requester and response bus of the palindrome checker scheduler.
// A word or result moves on a clock edge where its valid and ready are both high;
// valid never waits on ready, and a valid holder keeps its payload until that edge.
interface palindrome_check_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_is_pal;
    logic [WIDTH-1:0]      rsp_word;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_is_pal, rsp_word
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_is_pal, rsp_word
    );
endinterface

// File: rtl/palindrome_bits.sv
// Combinational bit-palindrome test; for odd WIDTH the middle bit is not compared.
module palindrome_bits #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data,
    output logic             is_pal
);
    always_comb begin
        is_pal = 1'b1;
        for (int i = 0; i < WIDTH / 2; i++) begin
            if (data[i] != data[WIDTH-1-i]) is_pal = 1'b0;
        end
    end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr upward, ptr moves past each winner.
module rr_arbiter
    import palindrome_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any,
    output logic [IDW-1:0]  ptr
);
    logic [MAX_NREQ-1:0] valid_ext;
    pick_t               pick;

    always_comb begin
        valid_ext            = '0;
        valid_ext[NREQ-1:0]  = req_valid;
        pick                 = rr_pick(valid_ext, int'(ptr), NREQ);
        grant_any            = enable && pick.found;
        grant_idx            = pick.index[IDW-1:0];
        grant                = '0;
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
endmodule

// File: rtl/palindrome_check_sched.sv
// Shares one palindrome_bits checker between NREQ requesters through a round-robin
// arbiter; results sit in a one-entry register with valid/ready backpressure.
module palindrome_check_sched
    import palindrome_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = 4,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    palindrome_check_sched_if.slave  bus,
    output logic [CNTW-1:0]          hit_count,
    output logic [$clog2(NREQ)-1:0]  dbg_ptr
);
    localparam int IDW = $clog2(NREQ);

    logic             slot_free;
    logic             grant_any;
    logic [IDW-1:0]   grant_idx;
    logic [WIDTH-1:0] sel_word;
    logic             sel_pal;

    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic             rsp_is_pal;
    logic [WIDTH-1:0] rsp_word;

    // Slot is free when empty or being drained this cycle; reset blocks all grants.
    assign slot_free = !rsp_valid || bus.rsp_ready;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (bus.req_valid),
        .enable    (slot_free && rst_n),
        .grant     (bus.req_ready),
        .grant_idx (grant_idx),
        .grant_any (grant_any),
        .ptr       (dbg_ptr)
    );

    assign sel_word = bus.req_data[grant_idx*WIDTH +: WIDTH];

    palindrome_bits #(.WIDTH(WIDTH)) u_chk (
        .data   (sel_word),
        .is_pal (sel_pal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_is_pal <= 1'b0;
            rsp_word   <= '0;
        end else if (grant_any) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= grant_idx;
            rsp_is_pal <= sel_pal;
            rsp_word   <= sel_word;
        end else if (bus.rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count <= '0;
        end else if (rsp_valid && bus.rsp_ready && rsp_is_pal && (hit_count != '1)) begin
            hit_count <= hit_count + 1'b1;
        end
    end

    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_id     = rsp_id;
    assign bus.rsp_is_pal = rsp_is_pal;
    assign bus.rsp_word   = rsp_word;
endmodule
